// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multiport register file and its clear sequencer.
package reg_file_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;

    function automatic logic rf_addr_valid(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_clear_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on clear_req.
module reg_clear_seq
    import reg_file_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    rf_state_e         state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RF_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy       = 1'b0;
        clear_done = 1'b0;
        clr_we     = 1'b0;
        clr_addr   = cnt;
        unique case (state)
            RF_IDLE: begin
                if (clear_req) begin
                    state_next = RF_CLEAR;
                    cnt_next   = '0;
                end
            end
            RF_CLEAR: begin
                busy = 1'b1;
                // Gate with reset so nothing pulses or writes while reset is held.
                clr_we     = reset;
                clear_done = reset && (cnt == LastAddr);
                if (cnt == LastAddr) begin
                    state_next = RF_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = RF_CLEAR;
        endcase
    end

endmodule

// File: rtl/reg_file_multiport.sv
// Multiport register file with write-through bypass, optional zero entry and clear sweep.
module reg_file_multiport
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wbdata,
    output logic                     wr_ready,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     clear_done
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_accept;
    logic              port_wr_en;
    logic [DATA_W-1:0] mem [DEPTH];

    reg_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr)
    );

    assign wr_ready   = !busy && !clear_req;
    assign wr_accept  = we && wr_ready;
    assign port_wr_en = wr_accept && rf_addr_valid(32'(waddr), DEPTH)
                        && !((ZERO_REG != 0) && (waddr == '0));

    // No reset on the array: contents are defined only by the clear sweep.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (port_wr_en) begin
            mem[waddr] <= wbdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[p*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            if (busy) begin
                rd = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end else if (!rf_addr_valid(32'(ra), DEPTH)) begin
                rd = '0;
            end else if (wr_accept && (waddr == ra)) begin
                rd = wbdata;
            end else begin
                rd = mem[ra];
            end
        end

        assign rdata[p*DATA_W +: DATA_W] = rd;
    end

endmodule
